// File: rtl/wash_program_sequencer_if.sv
// Front-panel, sensor and actuator signals of the wash program sequencer.
// The master side drives the panel/sensor inputs; the slave side is the sequencer.
interface wash_program_sequencer_if #(
  parameter int unsigned TIMER_W = 8
);
  logic               tick;
  logic               start;
  logic               pause;
  logic               abort;
  logic [1:0]         prog_sel;
  logic               full;
  logic               empty;
  logic               cold;
  logic               ready;
  logic               water_in;
  logic               heat_r;
  logic               wash;
  logic               drain;
  logic               speed;
  logic               done;
  logic               fault;
  logic [2:0]         phase;
  logic [TIMER_W-1:0] remaining;

  modport master (
    output tick, start, pause, abort, prog_sel, full, empty, cold,
    input  ready, water_in, heat_r, wash, drain, speed, done, fault, phase, remaining
  );

  modport slave (
    input  tick, start, pause, abort, prog_sel, full, empty, cold,
    output ready, water_in, heat_r, wash, drain, speed, done, fault, phase, remaining
  );
endinterface

// File: rtl/wash_program_sequencer.sv
// Washing-machine cycle sequencer: fill, heat, wash, drain, spin with one shared
// tick-driven phase counter (down for timed phases, up for level-timeout supervision).
module wash_program_sequencer #(
  parameter int unsigned WASH_NORMAL  = 40,
  parameter int unsigned WASH_QUICK   = 20,
  parameter int unsigned SPIN_LEN     = 20,
  parameter int unsigned FILL_TIMEOUT = 100,
  parameter int unsigned TIMER_W      = 8
) (
  input logic                     clk,
  input logic                     reset,
  wash_program_sequencer_if.slave bus
);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] FILL  = 3'd1;
  localparam logic [2:0] HEAT  = 3'd2;
  localparam logic [2:0] WASH  = 3'd3;
  localparam logic [2:0] DRAIN = 3'd4;
  localparam logic [2:0] SPIN  = 3'd5;
  localparam logic [2:0] DONE  = 3'd6;
  localparam logic [2:0] FAULT = 3'd7;

  localparam logic [TIMER_W-1:0] WN_V  = TIMER_W'(WASH_NORMAL);
  localparam logic [TIMER_W-1:0] WQ_V  = TIMER_W'(WASH_QUICK);
  localparam logic [TIMER_W-1:0] SP_V  = TIMER_W'(SPIN_LEN);
  localparam logic [TIMER_W-1:0] FT_V  = TIMER_W'(FILL_TIMEOUT);
  localparam logic [TIMER_W-1:0] FT_M1 = TIMER_W'(FILL_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] ONE   = TIMER_W'(1);

  logic [2:0]         state;
  logic [TIMER_W-1:0] cnt;
  logic               aborted;
  logic [1:0]         prog;
  logic               active;
  logic               hold;

  assign active = (state == FILL) || (state == HEAT) || (state == WASH) ||
                  (state == DRAIN) || (state == SPIN);
  assign hold   = bus.pause && active;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      aborted <= 1'b0;
      prog    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start && !bus.abort) begin
            prog  <= bus.prog_sel;
            cnt   <= '0;
            state <= (bus.prog_sel == 2'd2) ? DRAIN : FILL;
          end
        end
        FILL, HEAT, WASH: begin
          if (bus.abort) begin
            state   <= DRAIN;
            cnt     <= '0;
            aborted <= 1'b1;
          end else if (!bus.pause) begin
            if (state == FILL) begin
              if (bus.full) begin
                state <= HEAT;
              end else if (bus.tick) begin
                if (cnt >= FT_M1) begin
                  state <= FAULT;
                  cnt   <= FT_V;
                end else begin
                  cnt <= cnt + ONE;
                end
              end
            end else if (state == HEAT) begin
              if (!bus.cold) begin
                state <= WASH;
                cnt   <= (prog == 2'd1) ? WQ_V : WN_V;
              end
            end else if (bus.tick) begin
              if (cnt <= ONE) begin
                state <= DRAIN;
                cnt   <= '0;
              end else begin
                cnt <= cnt - ONE;
              end
            end
          end
        end
        DRAIN: begin
          if (bus.abort) aborted <= 1'b1;
          if (!bus.pause) begin
            // An abort seen in the same cycle as empty still skips the spin.
            if (bus.empty) begin
              if (aborted || bus.abort) begin
                state   <= IDLE;
                cnt     <= '0;
                aborted <= 1'b0;
              end else begin
                state <= SPIN;
                cnt   <= SP_V;
              end
            end else if (bus.tick) begin
              if (cnt >= FT_M1) begin
                state <= FAULT;
                cnt   <= FT_V;
              end else begin
                cnt <= cnt + ONE;
              end
            end
          end
        end
        SPIN: begin
          if (bus.abort) begin
            state   <= IDLE;
            cnt     <= '0;
            aborted <= 1'b0;
          end else if (!bus.pause && bus.tick) begin
            if (cnt <= ONE) begin
              state <= DONE;
              cnt   <= '0;
            end else begin
              cnt <= cnt - ONE;
            end
          end
        end
        DONE: begin
          state   <= IDLE;
          cnt     <= '0;
          aborted <= 1'b0;
        end
        default: begin
          if (bus.abort) begin
            state   <= IDLE;
            cnt     <= '0;
            aborted <= 1'b0;
          end
        end
      endcase
    end
  end

  always_comb begin
    bus.ready     = (state == IDLE);
    bus.done      = (state == DONE);
    bus.fault     = (state == FAULT);
    bus.phase     = state;
    bus.remaining = cnt;
    bus.water_in  = !hold && (state == FILL);
    bus.heat_r    = !hold && (state == HEAT) && bus.cold;
    bus.wash      = !hold && (state == WASH);
    bus.drain     = !hold && ((state == DRAIN) || (state == SPIN));
    bus.speed     = !hold && (state == SPIN);
  end
endmodule

// File: tb/tb_wash_program_sequencer.sv
// Self-checking bench for wash_program_sequencer: a table of opening vectors plus
// hand-built multi-cycle sequences, all routed through an expected-value queue.
module tb_wash_program_sequencer;
  logic clk;
  logic reset;

  wash_program_sequencer_if #(.TIMER_W(8)) bus ();

  wash_program_sequencer #(
    .WASH_NORMAL (40),
    .WASH_QUICK  (20),
    .SPIN_LEN    (20),
    .FILL_TIMEOUT(100),
    .TIMER_W     (8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected actuator vector order: {ready, water_in, heat_r, wash, drain, speed, done, fault}
  localparam logic [7:0] A_IDLE  = 8'b1000_0000;
  localparam logic [7:0] A_FILL  = 8'b0100_0000;
  localparam logic [7:0] A_HEAT  = 8'b0010_0000;
  localparam logic [7:0] A_WASH  = 8'b0001_0000;
  localparam logic [7:0] A_DRAIN = 8'b0000_1000;
  localparam logic [7:0] A_SPIN  = 8'b0000_1100;
  localparam logic [7:0] A_DONE  = 8'b0000_0010;
  localparam logic [7:0] A_FAULT = 8'b0000_0001;
  localparam logic [7:0] A_NONE  = 8'b0000_0000;

  typedef struct {
    string      name;
    logic       rst, tick, start, pause, abort;
    logic [1:0] prog;
    logic       full, empty, cold;
    logic [7:0] acts;
    logic [2:0] ph;
    logic [7:0] rem;
    logic       rem_chk;
  } vec_t;

  vec_t exp_q[$];
  vec_t tbl[7];
  int   checks = 0;
  int   errors = 0;

  // Current input levels used by the hand-written sequences.
  logic       i_rst, i_tick, i_start, i_pause, i_abort, i_full, i_empty, i_cold;
  logic [1:0] i_prog;

  function automatic vec_t mk(input string name, input logic rst, input logic tick,
                              input logic start, input logic pause, input logic abort,
                              input logic [1:0] prog, input logic full, input logic empty,
                              input logic cold, input logic [7:0] acts, input logic [2:0] ph,
                              input logic [7:0] rem, input logic rem_chk);
    vec_t v;
    v.name = name; v.rst = rst; v.tick = tick; v.start = start; v.pause = pause;
    v.abort = abort; v.prog = prog; v.full = full; v.empty = empty; v.cold = cold;
    v.acts = acts; v.ph = ph; v.rem = rem; v.rem_chk = rem_chk;
    return v;
  endfunction

  task automatic run_vec(input vec_t v);
    vec_t       e;
    logic [7:0] got_acts;
    i_rst = v.rst; i_tick = v.tick; i_start = v.start; i_pause = v.pause; i_abort = v.abort;
    i_prog = v.prog; i_full = v.full; i_empty = v.empty; i_cold = v.cold;
    reset        = v.rst;
    bus.tick     = v.tick;
    bus.start    = v.start;
    bus.pause    = v.pause;
    bus.abort    = v.abort;
    bus.prog_sel = v.prog;
    bus.full     = v.full;
    bus.empty    = v.empty;
    bus.cold     = v.cold;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    got_acts = {bus.ready, bus.water_in, bus.heat_r, bus.wash, bus.drain, bus.speed,
                bus.done, bus.fault};
    checks++;
    if (got_acts !== e.acts || bus.phase !== e.ph || (e.rem_chk && bus.remaining !== e.rem)) begin
      errors++;
      $display("FAIL %s: acts=%b phase=%0d remaining=%0d, required acts=%b phase=%0d remaining=%0d%s",
               e.name, got_acts, bus.phase, bus.remaining, e.acts, e.ph, e.rem,
               e.rem_chk ? "" : " (remaining unchecked)");
    end
  endtask

  task automatic step(input string name, input logic [7:0] acts, input logic [2:0] ph,
                      input logic [7:0] rem, input logic rem_chk);
    run_vec(mk(name, i_rst, i_tick, i_start, i_pause, i_abort, i_prog, i_full, i_empty,
               i_cold, acts, ph, rem, rem_chk));
  endtask

  initial begin
    // name, rst, tick, start, pause, abort, prog, full, empty, cold, acts, phase, rem, rem_chk
    tbl[0] = mk("reset",        1, 1, 0, 0, 0, 2'd0, 0, 0, 0, A_IDLE, 3'd0, 8'd0,  1);
    tbl[1] = mk("start_abort",  0, 1, 1, 0, 1, 2'd1, 0, 0, 0, A_IDLE, 3'd0, 8'd0,  1);
    tbl[2] = mk("start_quick",  0, 1, 1, 0, 0, 2'd1, 0, 0, 0, A_FILL, 3'd1, 8'd0,  1);
    tbl[3] = mk("fill_tick1",   0, 1, 0, 0, 0, 2'd2, 0, 0, 0, A_FILL, 3'd1, 8'd1,  1);
    tbl[4] = mk("fill_tick2",   0, 1, 0, 0, 0, 2'd2, 0, 0, 0, A_FILL, 3'd1, 8'd2,  1);
    tbl[5] = mk("full_to_heat", 0, 1, 0, 0, 0, 2'd2, 1, 0, 0, A_NONE, 3'd2, 8'd0,  0);
    tbl[6] = mk("heat_to_wash", 0, 1, 0, 0, 0, 2'd2, 1, 0, 0, A_WASH, 3'd3, 8'd20, 1);
    for (int unsigned k = 0; k < 7; k++) run_vec(tbl[k]);

    // Program 1 continued: 20-cycle wash, drain, 20-cycle spin, one-cycle done.
    i_full = 0; i_prog = 2'd0;
    for (int i = 1; i < 20; i++) step("quick_wash", A_WASH, 3'd3, 8'(20 - i), 1);
    step("wash_end", A_DRAIN, 3'd4, 8'd0, 1);
    step("drain_wait", A_DRAIN, 3'd4, 8'd1, 1);
    i_empty = 1;
    step("spin_entry", A_SPIN, 3'd5, 8'd20, 1);
    i_empty = 0;
    for (int i = 1; i < 20; i++) step("quick_spin", A_SPIN, 3'd5, 8'(20 - i), 1);
    step("done_pulse", A_DONE, 3'd6, 8'd0, 1);
    step("after_done", A_IDLE, 3'd0, 8'd0, 1);
    step("idle_stays", A_IDLE, 3'd0, 8'd0, 1);

    // Program 0: heater on for exactly the 5 cold cycles, then 40-tick wash with a pause.
    i_start = 1; i_prog = 2'd0;
    step("start_normal", A_FILL, 3'd1, 8'd0, 1);
    i_start = 0; i_full = 1; i_cold = 1;
    step("heat_cold1", A_HEAT, 3'd2, 8'd0, 0);
    for (int i = 0; i < 4; i++) step("heat_cold", A_HEAT, 3'd2, 8'd0, 0);
    i_cold = 0; i_full = 0;
    step("normal_wash", A_WASH, 3'd3, 8'd40, 1);
    for (int i = 1; i <= 30; i++) step("wash_count", A_WASH, 3'd3, 8'(40 - i), 1);
    i_pause = 1;
    for (int i = 0; i < 7; i++) step("wash_paused", A_NONE, 3'd3, 8'd10, 1);
    i_pause = 0;
    for (int i = 1; i < 10; i++) step("wash_resume", A_WASH, 3'd3, 8'(10 - i), 1);
    step("wash_resume_end", A_DRAIN, 3'd4, 8'd0, 1);
    i_pause = 1; i_empty = 1;
    step("drain_paused", A_NONE, 3'd4, 8'd0, 1);
    i_pause = 0;
    step("spin_normal", A_SPIN, 3'd5, 8'd20, 1);
    i_empty = 0; i_abort = 1;
    step("spin_abort", A_IDLE, 3'd0, 8'd0, 1);
    i_abort = 0;
    step("no_done_abort", A_IDLE, 3'd0, 8'd0, 1);

    // Fill timeout: 100 ticks without full (one tick-less cycle holds the count).
    i_start = 1;
    step("start_timeout", A_FILL, 3'd1, 8'd0, 1);
    i_start = 0;
    for (int i = 1; i < 50; i++) step("fill_up", A_FILL, 3'd1, 8'(i), 1);
    i_tick = 0;
    step("fill_no_tick", A_FILL, 3'd1, 8'd49, 1);
    i_tick = 1;
    for (int i = 50; i < 100; i++) step("fill_up", A_FILL, 3'd1, 8'(i), 1);
    step("fill_timeout", A_FAULT, 3'd7, 8'd100, 1);
    i_start = 1;
    step("fault_ignores_start", A_FAULT, 3'd7, 8'd100, 1);
    i_start = 0; i_abort = 1;
    step("fault_abort", A_IDLE, 3'd0, 8'd0, 1);

    // Restart after fault, abort (with pause) mid-wash, drain then straight to IDLE.
    i_abort = 0; i_start = 1; i_prog = 2'd1;
    step("restart", A_FILL, 3'd1, 8'd0, 1);
    i_start = 0; i_full = 1;
    step("restart_heat", A_NONE, 3'd2, 8'd0, 0);
    i_full = 0;
    step("restart_wash", A_WASH, 3'd3, 8'd20, 1);
    step("restart_wash_tick", A_WASH, 3'd3, 8'd19, 1);
    i_abort = 1; i_pause = 1;
    step("wash_abort_paused", A_NONE, 3'd4, 8'd0, 1);
    i_abort = 0; i_pause = 0;
    step("abort_drain", A_DRAIN, 3'd4, 8'd1, 1);
    i_empty = 1;
    step("abort_drain_empty", A_IDLE, 3'd0, 8'd0, 1);
    i_empty = 0;
    step("abort_no_done", A_IDLE, 3'd0, 8'd0, 1);

    // Program 2: drain then spin; pause in spin, then reset mid-spin.
    i_start = 1; i_prog = 2'd2;
    step("spin_only", A_DRAIN, 3'd4, 8'd0, 1);
    i_start = 0; i_empty = 1;
    step("spin_only_spin", A_SPIN, 3'd5, 8'd20, 1);
    for (int i = 1; i <= 15; i++) step("spin_only_count", A_SPIN, 3'd5, 8'(20 - i), 1);
    i_pause = 1;
    step("spin_paused", A_NONE, 3'd5, 8'd5, 1);
    i_pause = 0; i_rst = 1;
    step("reset_mid_spin", A_IDLE, 3'd0, 8'd0, 1);
    i_rst = 0; i_empty = 0;
    step("after_reset", A_IDLE, 3'd0, 8'd0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
